// File: rtl/uart_tx_buffered.sv
// Buffered 8N1/8N2 UART transmitter: a circular FIFO feeds a start/data/stop
// serializer paced by a 16x baud tick, with FIFO and line status outputs.
module uart_tx_buffered #(
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_x16_tick,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [7:0]               tx_data,
  output logic                     uart_tx,
  output logic                     tx_busy,
  output logic                     tx_fifo_full,
  output logic                     tx_fifo_empty,
  output logic [$clog2(DEPTH):0]   tx_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    shift_q;
  logic [7:0]    shift_nxt;
  logic [3:0]    tick_cnt;
  logic [3:0]    tick_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic          stop_cnt;
  logic          stop_nxt;
  logic          tx_nxt;

  logic          push;
  logic          pop;
  logic          bit_end;

  assign tx_fifo_full  = (count == FULL_COUNT);
  assign tx_fifo_empty = (count == '0);
  assign tx_fifo_count = count;
  assign tx_ready      = !tx_fifo_full;
  assign tx_busy       = (state != IDLE) || !tx_fifo_empty;

  assign push    = tx_valid && tx_ready;
  assign pop     = (state == IDLE) && !tx_fifo_empty;
  assign bit_end = baud_x16_tick && (tick_cnt == 4'd15);

  // Storage is not reset; clearing the pointers and count discards contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_cnt;
    tx_nxt    = 1'b1;

    if ((state != IDLE) && baud_x16_tick) begin
      tick_nxt = tick_cnt + 4'd1;
    end

    case (state)
      IDLE: begin
        if (pop) begin
          shift_nxt = mem[rd_ptr];
          tick_nxt  = 4'd0;
          bit_nxt   = 3'd0;
          stop_nxt  = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = {1'b0, shift_q[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            stop_nxt  = 1'b0;
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        // A second stop bit is one more 16-tick period before going idle.
        if (bit_end) begin
          if ((STOP_BITS == 2) && !stop_cnt) begin
            stop_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The line level is decoded from the next state so uart_tx is a clean flop.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= 8'd0;
      tick_cnt <= 4'd0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      tick_cnt <= tick_nxt;
      bit_idx  <= bit_nxt;
      stop_cnt <= stop_nxt;
      uart_tx  <= tx_nxt;
    end
  end

endmodule
